fp_issue_scoreboard: RTL and testbench

Issue controller for the floating-point register file and the non-pipelined FPU, sitting beside the decode stage and its integer hazard detector. It tracks in-flight FP register writes, detects RAW, WAW, write-port and FPU-busy hazards for the instruction in decode, and stalls it until issue is safe. It also sequences the single FP write port (FBUS_W) by scheduling every FP writeback into a reserved cycle.

---
 rtl/fp_issue_scoreboard.sv | 114 +++++++++++
 tb/tb_fp_issue_scoreboard.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_scoreboard.sv
// FP issue controller: tracks in-flight FP register writes, stalls decode on
// RAW/WAW/write-port/FPU-busy hazards and schedules the single FP write port.
module fp_issue_scoreboard #(
    parameter int unsigned FPU_LATENCY = 5,
    parameter int unsigned WB_LAT      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic       fpu_op,
    input  logic       f_reg_wr,
    input  logic [4:0] f_rw,
    input  logic [4:0] f_rs,
    input  logic [4:0] f_rt,
    input  logic       f_rs_used,
    input  logic       f_rt_used,
    output logic       stall_fp,
    output logic       fpu_start,
    output logic       fpu_busy,
    output logic       wb_en,
    output logic [4:0] wb_rw,
    output logic       wb_from_fpu
);

    typedef struct packed {
        logic       v;
        logic [4:0] r;
        logic       f;
    } slot_t;

    // Slot k holds the write due k cycles from now. A writer issued this
    // cycle lands one step closer after the edge, so slot FPU_LATENCY is
    // never occupied and only slots 1..FPU_LATENCY-1 need storage.
    localparam int unsigned NS = FPU_LATENCY - 1;

    slot_t       slots [1:NS];
    slot_t       nxt   [0:NS];
    logic [3:0]  busy_cnt;
    logic [3:0]  busy_cnt_nxt;
    int unsigned lat;
    logic        hit_rs;
    logic        hit_rt;
    logic        hit_rw;
    logic        port_hit;
    logic        ins;

    always_comb begin
        lat      = fpu_op ? FPU_LATENCY : WB_LAT;
        hit_rs   = wb_en && (wb_rw == f_rs);
        hit_rt   = wb_en && (wb_rw == f_rt);
        hit_rw   = wb_en && (wb_rw == f_rw);
        port_hit = 1'b0;
        for (int unsigned k = 1; k <= NS; k++) begin
            if (slots[k].v) begin
                if (slots[k].r == f_rs) hit_rs = 1'b1;
                if (slots[k].r == f_rt) hit_rt = 1'b1;
                if (slots[k].r == f_rw) hit_rw = 1'b1;
                if (k == lat)           port_hit = 1'b1;
            end
        end
    end

    assign stall_fp = issue_valid && !reset &&
                      ((f_rs_used && hit_rs) ||
                       (f_rt_used && hit_rt) ||
                       (f_reg_wr && (hit_rw || port_hit)) ||
                       (fpu_op && fpu_busy));

    assign fpu_start = issue_valid && fpu_op && !stall_fp && !reset;
    assign ins       = issue_valid && f_reg_wr && !stall_fp && !reset;

    // Shift toward writeback and insert the issuing writer in the same step;
    // index 0 is the value the writeback register takes at the edge.
    always_comb begin
        for (int unsigned k = 0; k <= NS; k++) begin
            nxt[k] = '0;
        end
        for (int unsigned k = 0; k < NS; k++) begin
            nxt[k] = slots[k + 1];
        end
        for (int unsigned k = 0; k <= NS; k++) begin
            if (ins && (k + 1 == lat)) nxt[k] = {1'b1, f_rw, fpu_op};
        end
    end

    always_comb begin
        busy_cnt_nxt = busy_cnt;
        if (fpu_start)             busy_cnt_nxt = 4'(FPU_LATENCY - 1);
        else if (busy_cnt != '0)   busy_cnt_nxt = busy_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 1; k <= NS; k++) begin
                slots[k] <= '0;
            end
            wb_en       <= 1'b0;
            wb_rw       <= '0;
            wb_from_fpu <= 1'b0;
            busy_cnt    <= '0;
            fpu_busy    <= 1'b0;
        end else begin
            for (int unsigned k = 1; k <= NS; k++) begin
                slots[k] <= nxt[k];
            end
            wb_en       <= nxt[0].v;
            wb_rw       <= nxt[0].r;
            wb_from_fpu <= nxt[0].f;
            busy_cnt    <= busy_cnt_nxt;
            fpu_busy    <= (busy_cnt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Bench for fp_issue_scoreboard: per-cycle vector table with expected stalls;
// writebacks are predicted into a queue at issue and matched when due.
module tb_fp_issue_scoreboard;

    localparam int FPU_LAT = 5;
    localparam int WB_L    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, fpu_op, f_reg_wr, f_rs_used, f_rt_used;
    logic [4:0] f_rw, f_rs, f_rt;
    logic       stall_fp, fpu_start, fpu_busy, wb_en, wb_from_fpu;
    logic [4:0] wb_rw;

    fp_issue_scoreboard #(.FPU_LATENCY(FPU_LAT), .WB_LAT(WB_L)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .fpu_op(fpu_op),
        .f_reg_wr(f_reg_wr), .f_rw(f_rw), .f_rs(f_rs), .f_rt(f_rt),
        .f_rs_used(f_rs_used), .f_rt_used(f_rt_used), .stall_fp(stall_fp),
        .fpu_start(fpu_start), .fpu_busy(fpu_busy), .wb_en(wb_en),
        .wb_rw(wb_rw), .wb_from_fpu(wb_from_fpu)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       v;
        bit       fpu;
        bit       wr;
        bit [4:0] rw;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       rsu;
        bit       rtu;
        bit       exp_stall;
    } vec_t;

    typedef struct {
        int       due;
        bit [4:0] rw;
        bit       from_fpu;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input bit rst, input bit v, input bit fpu, input bit wr,
                       input bit [4:0] rw, input bit [4:0] rs, input bit [4:0] rt,
                       input bit rsu, input bit rtu, input bit exp_stall);
        vec_t e;
        e.rst = rst; e.v = v; e.fpu = fpu; e.wr = wr; e.rw = rw; e.rs = rs;
        e.rt = rt; e.rsu = rsu; e.rtu = rtu; e.exp_stall = exp_stall;
        vecs.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  last_start;
        bit  prev_rst;
        bit  exp_start, exp_busy, found;
        int  idx;
        vec_t e;
        wb_t w;

        // reset held two cycles with a non-FP instruction present
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // FPU op writing F2: busy 4 cycles, writeback 5 cycles later
        add(0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        idle(6);
        // RAW on F4: reader stalls until the writeback cycle has passed
        add(0, 1, 1, 1, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 4, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 4, 0, 1, 0, 0);
        idle(3);
        // write-port conflict: load due in the same cycle as the FPU result
        add(0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        idle(1);
        add(0, 1, 0, 1, 6, 0, 0, 0, 0, 1);
        add(0, 1, 0, 1, 6, 0, 0, 0, 0, 0);
        idle(5);
        // back-to-back independent FPU ops
        add(0, 1, 1, 1, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 1, 1, 12, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 12, 0, 0, 0, 0, 0);
        idle(7);
        // reset mid-flight discards the F8 reservation and the busy count
        add(0, 1, 1, 1, 8, 0, 0, 0, 0, 0);
        idle(1);
        add(1, 1, 1, 0, 0, 8, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8, 0, 1, 0, 0);
        idle(8);
        // WAW on F0, then compare reading F0 via source B: busy then RAW
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 0, 7, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 7, 0, 0, 1, 0);
        idle(6);
        // unused sources never stall; used source B does
        add(0, 1, 0, 1, 9, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9, 9, 0, 0, 0);
        add(0, 1, 0, 0, 0, 3, 9, 0, 1, 1);
        add(0, 1, 0, 0, 0, 3, 9, 0, 1, 1);
        add(0, 1, 0, 0, 0, 3, 9, 0, 1, 0);
        idle(4);

        reset = 1'b1; issue_valid = 0; fpu_op = 0; f_reg_wr = 0;
        f_rw = 0; f_rs = 0; f_rt = 0; f_rs_used = 0; f_rt_used = 0;
        repeat (2) @(posedge clk);
        #1;

        last_start = -100;
        prev_rst   = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            e = vecs[i];
            reset = e.rst; issue_valid = e.v; fpu_op = e.fpu; f_reg_wr = e.wr;
            f_rw = e.rw; f_rs = e.rs; f_rt = e.rt;
            f_rs_used = e.rsu; f_rt_used = e.rtu;
            #3;
            exp_start = e.v && e.fpu && !e.exp_stall && !e.rst;
            exp_busy  = (i > last_start) && (i < last_start + FPU_LAT);
            chk("stall_fp", i, 32'(stall_fp), 32'(e.exp_stall));
            chk("fpu_start", i, 32'(fpu_start), 32'(exp_start));
            chk("fpu_busy", i, 32'(fpu_busy), 32'(exp_busy));

            found = 1'b0;
            idx   = 0;
            for (int q = 0; q < sb.size(); q++) begin
                if (!found && sb[q].due == i) begin
                    found = 1'b1;
                    idx   = q;
                end
            end
            chk("wb_en", i, 32'(wb_en), 32'(found));
            if (found) begin
                w = sb[idx];
                sb.delete(idx);
                chk("wb_rw", i, 32'(wb_rw), 32'(w.rw));
                chk("wb_from_fpu", i, 32'(wb_from_fpu), 32'(w.from_fpu));
            end
            if (prev_rst) begin
                chk("wb_rw_reset", i, 32'(wb_rw), 32'd0);
                chk("wb_from_fpu_reset", i, 32'(wb_from_fpu), 32'd0);
            end

            if (e.v && !e.exp_stall && !e.rst && e.wr) begin
                w.due      = i + (e.fpu ? FPU_LAT : WB_L);
                w.rw       = e.rw;
                w.from_fpu = e.fpu;
                sb.push_back(w);
            end
            if (exp_start) last_start = i;
            if (e.rst) begin
                sb.delete();
                last_start = -100;
            end
            prev_rst = e.rst;
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
